// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds default widths and reset PC for the fetch unit, plus the queue entry
// layout {ins, next_pc} at those default widths for consumers of the queue.
package cpu_fetch_pkg;

    localparam int unsigned FETCH_ADDR_W   = 7;
    localparam int unsigned FETCH_DATA_W   = 32;
    localparam int unsigned FETCH_RESET_PC = 0;

    // One instruction-queue entry: fetched word and the PC that follows it.
    typedef struct packed {
        logic [FETCH_DATA_W-1:0] ins;
        logic [FETCH_ADDR_W-1:0] next_pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Handshake bundle of the fetch unit: redirect input, instruction-memory
// request/grant/response channel and the instruction queue head towards ID.
//   master : fetch unit view (drives imem request and ID head)
//   slave  : environment view (memory, ID stage, branch resolution)
interface fetch_queue_unit_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DATA_W-1:0] imem_rdata_i;
    logic              id_valid_o;
    logic [DATA_W-1:0] id_ins_o;
    logic [ADDR_W-1:0] id_next_pc_o;
    logic              id_ready_i;
    logic [CntW-1:0]   q_count_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output imem_req_o, imem_addr_o, id_valid_o, id_ins_o, id_next_pc_o, q_count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  imem_req_o, imem_addr_o, id_valid_o, id_ins_o, id_next_pc_o, q_count_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions for the ID stage.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write one entry (ignored when full unless popping too)
//   pop_i        : remove head (ignored when empty)
//   clear_i      : empty the FIFO; overrides push and pop
//   count_o      : occupancy 0..DEPTH
//   head_o       : head entry, zero when empty
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 39
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(DEPTH)) || do_pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only visible while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues word addresses to a variable-latency
// instruction memory and queues returned instructions with their PC+1 for ID.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus_io       : fetch_queue_unit_if.master
//     redirect_i/redirect_pc_i : flush queue, drop in-flight responses, reload PC
//     imem_req_o/imem_addr_o/imem_gnt_i : request channel (addr = fetch PC)
//     imem_rvalid_i/imem_rdata_i        : in-order response channel
//     id_valid_o/id_ins_o/id_next_pc_o/id_ready_i : queue head towards ID
//     q_count_o : queue occupancy
module fetch_queue_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned DATA_W   = FETCH_DATA_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fetch_queue_unit_if.master bus_io
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned OutW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [DATA_W-1:0] ins;
        logic [ADDR_W-1:0] next_pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OutW-1:0]   inflight_q, inflight_d;
    logic [OutW-1:0]   discard_q, discard_d;

    logic [CntW-1:0]   count;
    entry_t            head, push_entry;
    logic [31:0]       committed;
    logic              req, issue, rsp, keep, pop;

    // Slots already promised: queued entries plus responses that will be kept.
    assign committed = 32'(count) + 32'(inflight_q) - 32'(discard_q);

    // Reset gating keeps the request low while the unit is held in reset.
    assign req   = !rst_i && !bus_io.redirect_i && (inflight_q < OutW'(MAX_OUT))
                   && (committed < DEPTH);
    assign issue = req && bus_io.imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp   = bus_io.imem_rvalid_i && (inflight_q != '0);
    assign keep  = rsp && (discard_q == '0) && !bus_io.redirect_i;
    assign pop   = bus_io.id_valid_o && bus_io.id_ready_i;

    assign push_entry.ins     = bus_io.imem_rdata_i;
    assign push_entry.next_pc = resp_pc_q + ADDR_W'(1);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (bus_io.redirect_i) begin
            fetch_pc_d = bus_io.redirect_pc_i;
            resp_pc_d  = bus_io.redirect_pc_i;
            // Everything still outstanding after this cycle belongs to the old path.
            inflight_d = inflight_q - OutW'(rsp);
            discard_d  = inflight_q - OutW'(rsp);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (rsp) begin
                if (discard_q != '0) discard_d = discard_q - OutW'(1);
                else                 resp_pc_d = resp_pc_q + ADDR_W'(1);
            end
            inflight_d = inflight_q + OutW'(issue) - OutW'(rsp);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= ADDR_W'(RESET_PC);
            resp_pc_q  <= ADDR_W'(RESET_PC);
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (keep),
        .data_i  (push_entry),
        .pop_i   (pop),
        .clear_i (bus_io.redirect_i),
        .count_o (count),
        .head_o  (head)
    );

    assign bus_io.imem_req_o   = req;
    assign bus_io.imem_addr_o  = fetch_pc_q;
    assign bus_io.id_valid_o   = (count != '0);
    assign bus_io.id_ins_o     = head.ins;
    assign bus_io.id_next_pc_o = head.next_pc;
    assign bus_io.q_count_o    = count;

    rvalid_needs_inflight: assert property (
        @(posedge clk_i) disable iff (rst_i) bus_io.imem_rvalid_i |-> (inflight_q != '0)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios, a request-list/queue model
// checked every cycle, and literal expectations at key points.
module tb_fetch_queue_unit;
    import cpu_fetch_pkg::*;

    localparam int AW      = 7;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int PC_MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_unit_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

    fetch_queue_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Environment: memory answers the oldest granted address one cycle later.
    bit gnt_en, rsp_en;
    int mem_q[$];
    int grants;

    // Model: expected fetch/response PCs, outstanding requests (1 = kept), queue.
    int           m_fetch_pc, m_resp_pc;
    bit           m_pend[$];
    fetch_entry_t m_q[$];
    bit           m_exp_req;

    // Outputs sampled at the last compare point.
    logic          cap_req, cap_valid;
    logic [AW-1:0] cap_addr, cap_npc;
    logic [DW-1:0] cap_ins;
    logic [2:0]    cap_cnt;

    function automatic logic [DW-1:0] mem_word(int a);
        return 32'hC0DE_0000 + (32'(a) << 8) + 32'(a);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passes++;
    endtask

    function automatic int kept_pending();
        int n = 0;
        foreach (m_pend[i]) if (m_pend[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_fetch_pc = 0;
        m_resp_pc  = 0;
        m_pend.delete();
        m_q.delete();
        mem_q.delete();
    endtask

    task automatic compare();
        m_exp_req = !bus.redirect_i && (m_pend.size() < MAX_OUT)
                    && (m_q.size() + kept_pending() < DEPTH);
        chk("imem_req", bus.imem_req_o, m_exp_req);
        if (m_exp_req) chk("imem_addr", bus.imem_addr_o, m_fetch_pc);
        chk("id_valid", bus.id_valid_o, m_q.size() != 0);
        chk("q_count", bus.q_count_o, m_q.size());
        if (m_q.size() != 0) begin
            chk("id_ins", bus.id_ins_o, m_q[0].ins);
            chk("id_next_pc", bus.id_next_pc_o, m_q[0].next_pc);
        end
        cap_req   = bus.imem_req_o;
        cap_addr  = bus.imem_addr_o;
        cap_valid = bus.id_valid_o;
        cap_ins   = bus.id_ins_o;
        cap_npc   = bus.id_next_pc_o;
        cap_cnt   = bus.q_count_o;
    endtask

    task automatic model_update();
        bit           rv;
        bit           kept;
        fetch_entry_t e;
        rv = bus.imem_rvalid_i && (m_pend.size() > 0);
        if (bus.redirect_i) begin
            m_q.delete();
            if (rv) void'(m_pend.pop_front());
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_fetch_pc = int'(bus.redirect_pc_i);
            m_resp_pc  = int'(bus.redirect_pc_i);
        end else begin
            if (m_q.size() > 0 && bus.id_ready_i) void'(m_q.pop_front());
            if (rv) begin
                kept = m_pend.pop_front();
                if (kept) begin
                    e.ins     = bus.imem_rdata_i;
                    e.next_pc = 7'((m_resp_pc + 1) & PC_MASK);
                    m_q.push_back(e);
                    m_resp_pc = (m_resp_pc + 1) & PC_MASK;
                end
            end
            if (m_exp_req && bus.imem_gnt_i) begin
                m_pend.push_back(1'b1);
                m_fetch_pc = (m_fetch_pc + 1) & PC_MASK;
            end
        end
    endtask

    // One clock: inputs set by caller at the falling edge, compare, then advance.
    task automatic step();
        bus.imem_gnt_i = gnt_en;
        if (rsp_en && mem_q.size() > 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(mem_q[0]);
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
        #1 compare();
        @(posedge clk);
        model_update();
        if (bus.imem_rvalid_i) void'(mem_q.pop_front());
        if (cap_req && bus.imem_gnt_i) begin
            mem_q.push_back(int'(cap_addr));
            grants++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.redirect_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int found;
        int addrs[3];
        int npcs[3];
        int na, nv;

        rst = 1'b1;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        bus.id_ready_i = 1'b0;
        gnt_en = 1'b0;
        rsp_en = 1'b0;
        grants = 0;
        model_reset();
        @(negedge clk);
        chk("reset imem_req", bus.imem_req_o, 0);
        chk("reset id_valid", bus.id_valid_o, 0);
        chk("reset q_count", bus.q_count_o, 0);
        chk("reset id_ins", bus.id_ins_o, 0);
        chk("reset id_next_pc", bus.id_next_pc_o, 0);
        rst = 1'b0;

        // Streaming: addresses 0,1,2...; first valid two cycles after first request.
        gnt_en = 1; rsp_en = 1; bus.id_ready_i = 1;
        step(); chk("t1 req0", cap_req, 1); chk("t1 addr0", cap_addr, 0);
        step(); chk("t1 addr1", cap_addr, 1); chk("t1 no valid yet", cap_valid, 0);
        step(); chk("t1 first valid", cap_valid, 1); chk("t1 npc0", cap_npc, 1);
        chk("t1 ins0", cap_ins, mem_word(0)); chk("t1 addr2", cap_addr, 2);
        step(); chk("t1 npc1", cap_npc, 2);
        repeat (6) step();

        // ID stall: exactly DEPTH requests, then full queue drains in order.
        do_reset();
        bus.id_ready_i = 0; grants = 0;
        repeat (10) step();
        chk("t2 grants", grants, 4);
        chk("t2 count full", cap_cnt, 4);
        chk("t2 req blocked", cap_req, 0);
        bus.id_ready_i = 1;
        step(); chk("t2 drain head npc", cap_npc, 1);
        repeat (8) step();

        // Redirect with addresses 5,6 outstanding.
        do_reset();
        rsp_en = 0;
        bus.redirect_i = 1; bus.redirect_pc_i = 7'h05;
        step();
        bus.redirect_i = 0;
        step(); chk("t3 addr5", cap_addr, 5);
        step(); chk("t3 addr6", cap_addr, 6);
        step(); chk("t3 credit stop", cap_req, 0);
        bus.redirect_i = 1; bus.redirect_pc_i = 7'h40;
        step();
        bus.redirect_i = 0; rsp_en = 1;
        step(); chk("t3 flushed", cap_cnt, 0);
        found = -1;
        for (int i = 0; i < 10 && found < 0; i++) begin
            step();
            if (cap_req) found = int'(cap_addr);
        end
        chk("t3 new addr", found, 32'h40);
        found = -1;
        for (int i = 0; i < 10 && found < 0; i++) begin
            step();
            if (cap_valid) found = int'(cap_npc);
        end
        chk("t3 first npc", found, 32'h41);

        // Redirect coinciding with response, pop and issue opportunity.
        repeat (4) step();
        bus.redirect_i = 1; bus.redirect_pc_i = 7'h20;
        step(); chk("t4 req suppressed", cap_req, 0); chk("t4 pop offered", cap_valid, 1);
        bus.redirect_i = 0;
        step(); chk("t4 flushed", cap_cnt, 0);
        found = -1;
        for (int i = 0; i < 10 && found < 0; i++) begin
            step();
            if (cap_valid) found = int'(cap_npc);
        end
        chk("t4 first npc", found, 32'h21);

        // PC wrap at the top of the address space.
        bus.redirect_i = 1; bus.redirect_pc_i = 7'h7E;
        step();
        bus.redirect_i = 0;
        na = 0; nv = 0;
        for (int i = 0; i < 12 && (na < 3 || nv < 3); i++) begin
            step();
            if (cap_req && na < 3) begin addrs[na] = int'(cap_addr); na++; end
            if (cap_valid && nv < 3 && cap_npc != 7'h21) begin npcs[nv] = int'(cap_npc); nv++; end
        end
        chk("t5 addr 7E", addrs[0], 32'h7E);
        chk("t5 addr 7F", addrs[1], 32'h7F);
        chk("t5 addr 00", addrs[2], 32'h00);
        chk("t5 npc 7F", npcs[0], 32'h7F);
        chk("t5 npc wrap", npcs[1], 32'h00);
        chk("t5 npc 01", npcs[2], 32'h01);

        // Asynchronous reset with queued entries and requests in flight.
        do_reset();
        bus.id_ready_i = 0; rsp_en = 1;
        repeat (3) step();
        rsp_en = 0;
        step();
        chk("t6 pre count", bus.q_count_o, 2);
        chk("t6 pre valid", bus.id_valid_o, 1);
        #2 rst = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("t6 async req", bus.imem_req_o, 0);
        chk("t6 async valid", bus.id_valid_o, 0);
        chk("t6 async count", bus.q_count_o, 0);
        chk("t6 async ins", bus.id_ins_o, 0);
        chk("t6 async npc", bus.id_next_pc_o, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_en = 1; bus.id_ready_i = 1;
        step(); chk("t6 restart addr", cap_addr, 0); chk("t6 restart req", cap_req, 1);
        repeat (6) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
